// File: rtl/cp0_except_ctrl.sv
// CP0 exception/interrupt scheduler: arbitrates MEM-stage exceptions against pending
// interrupts, reports the winner to CP0, then drives a fixed-length flush and redirect PC.
module cp0_except_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_OFFSET   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic        exc_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_syscall_i,
  input  logic        exc_break_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0]  CNT_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] CODE_INT  = 32'h1;
  localparam logic [31:0] CODE_ADEL = 32'h10;
  localparam logic [31:0] CODE_RI   = 32'ha;
  localparam logic [31:0] CODE_SYS  = 32'h8;
  localparam logic [31:0] CODE_BRK  = 32'hf;
  localparam logic [31:0] CODE_OV   = 32'hc;
  localparam logic [31:0] CODE_TRAP = 32'hd;
  localparam logic [31:0] CODE_ERET = 32'he;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] new_pc_nxt;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic [31:0] vector;
  logic [31:0] code;
  logic        int_pending;
  logic        accept;
  logic        unused_bits;

  // An mtc0 still in WB has not reached the CP0 registers yet, so take its data.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: status_eff = wb_cp0_data_i;
        5'd13: begin
          cause_eff[9:8] = wb_cp0_data_i[9:8];
          cause_eff[22]  = wb_cp0_data_i[22];
          cause_eff[23]  = wb_cp0_data_i[23];
        end
        5'd14: epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign int_pending = status_eff[0] & ~status_eff[1]
                     & (|(cause_eff[15:8] & status_eff[15:8]));

  assign vector = {cp0_ebase_i[31:12], 12'h000} + EXC_OFFSET;

  always_comb begin
    code = 32'h0;
    if (rst && state == IDLE && mem_valid_i) begin
      if (int_pending)        code = CODE_INT;
      else if (exc_adel_i)    code = CODE_ADEL;
      else if (exc_ri_i)      code = CODE_RI;
      else if (exc_syscall_i) code = CODE_SYS;
      else if (exc_break_i)   code = CODE_BRK;
      else if (exc_ov_i)      code = CODE_OV;
      else if (exc_trap_i)    code = CODE_TRAP;
      else if (exc_eret_i)    code = CODE_ERET;
    end
  end

  assign accept = (code != 32'h0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    new_pc_nxt = new_pc_o;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = FLUSH;
          cnt_nxt    = CNT_INIT;
          new_pc_nxt = (code == CODE_ERET) ? epc_eff : vector;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      new_pc_o <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      new_pc_o <= new_pc_nxt;
    end
  end

  assign excepttype_o        = code;
  assign current_inst_addr_o = rst ? mem_inst_addr_i : 32'h0;
  assign is_in_delayslot_o   = rst & mem_in_delayslot_i;
  assign flush_o             = (state == FLUSH);
  assign busy_o              = (state == FLUSH);

  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16],
                         cause_eff[7:0], cp0_ebase_i[11:0]};

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed bench for cp0_except_ctrl: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_cp0_except_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_in_delayslot_i;
  logic        exc_adel_i, exc_ri_i, exc_syscall_i, exc_break_i;
  logic        exc_ov_i, exc_trap_i, exc_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int checks;
  int errors;

  cp0_except_ctrl #(.FLUSH_CYCLES(2), .EXC_OFFSET(32'h0000_0180)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid_i         (mem_valid_i),
    .mem_inst_addr_i     (mem_inst_addr_i),
    .mem_in_delayslot_i  (mem_in_delayslot_i),
    .exc_adel_i          (exc_adel_i),
    .exc_ri_i            (exc_ri_i),
    .exc_syscall_i       (exc_syscall_i),
    .exc_break_i         (exc_break_i),
    .exc_ov_i            (exc_ov_i),
    .exc_trap_i          (exc_trap_i),
    .exc_eret_i          (exc_eret_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .cp0_ebase_i         (cp0_ebase_i),
    .wb_cp0_we_i         (wb_cp0_we_i),
    .wb_cp0_waddr_i      (wb_cp0_waddr_i),
    .wb_cp0_data_i       (wb_cp0_data_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .busy_o              (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    mem_valid_i        = 1'b0;
    mem_inst_addr_i    = 32'h0;
    mem_in_delayslot_i = 1'b0;
    exc_adel_i         = 1'b0;
    exc_ri_i           = 1'b0;
    exc_syscall_i      = 1'b0;
    exc_break_i        = 1'b0;
    exc_ov_i           = 1'b0;
    exc_trap_i         = 1'b0;
    exc_eret_i         = 1'b0;
    cp0_status_i       = 32'h0;
    cp0_cause_i        = 32'h0;
    cp0_epc_i          = 32'h0;
    cp0_ebase_i        = 32'h8000_0000;
    wb_cp0_we_i        = 1'b0;
    wb_cp0_waddr_i     = 5'd0;
    wb_cp0_data_i      = 32'h0;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    mem_valid_i   = 1'b1;
    exc_syscall_i = 1'b1;
    mem_inst_addr_i = 32'h1234_5678;
    #12;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", flush_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc_o); end
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL reset_excepttype got %h exp 0", excepttype_o); end
    checks++; if (current_inst_addr_o !== 32'h0) begin errors++; $display("FAIL reset_inst_addr got %h exp 0", current_inst_addr_o); end
    clear_inputs();
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_syscall();
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1;
    mem_inst_addr_i = 32'hBFC0_0100; cp0_ebase_i = 32'h8000_0000;
    #1;
    checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL sys_code got %h exp 8", excepttype_o); end
    checks++; if (current_inst_addr_o !== 32'hBFC0_0100) begin errors++; $display("FAIL sys_addr got %h exp bfc00100", current_inst_addr_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL sys_flush_early got %0b exp 0", flush_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL sys_flush1 got %0b exp 1", flush_o); end
    checks++; if (new_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL sys_new_pc got %h exp 80000180", new_pc_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sys_busy got %0b exp 1", busy_o); end
    step();
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL sys_flush2 got %0b exp 1", flush_o); end
    checks++; if (new_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL sys_new_pc_hold got %h exp 80000180", new_pc_o); end
    step();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL sys_flush_end got %0b exp 0", flush_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sys_busy_end got %0b exp 0", busy_o); end
  endtask

  task automatic test_priority();
    mem_valid_i = 1'b1; exc_ri_i = 1'b1; exc_ov_i = 1'b1; exc_eret_i = 1'b1;
    #1;
    checks++; if (excepttype_o !== 32'ha) begin errors++; $display("FAIL prio_ri got %h exp a", excepttype_o); end
    clear_inputs();
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1;
    cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
    #1;
    checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL prio_int got %h exp 1", excepttype_o); end
    clear_inputs();
    mem_valid_i = 1'b1; exc_trap_i = 1'b1; exc_break_i = 1'b1;
    #1;
    checks++; if (excepttype_o !== 32'hf) begin errors++; $display("FAIL prio_brk got %h exp f", excepttype_o); end
    clear_inputs();
    mem_valid_i = 1'b1; exc_adel_i = 1'b1; exc_ri_i = 1'b1;
    #1;
    checks++; if (excepttype_o !== 32'h10) begin errors++; $display("FAIL prio_adel got %h exp 10", excepttype_o); end
    clear_inputs();
    mem_valid_i = 1'b1; exc_trap_i = 1'b1; exc_eret_i = 1'b1;
    #1;
    checks++; if (excepttype_o !== 32'hd) begin errors++; $display("FAIL prio_trap got %h exp d", excepttype_o); end
    clear_inputs();
    step();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL prio_no_accept got %0b exp 0", flush_o); end
  endtask

  task automatic test_eret_forward();
    mem_valid_i = 1'b1; exc_eret_i = 1'b1; cp0_epc_i = 32'h0000_1000;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h0000_2000;
    #1;
    checks++; if (excepttype_o !== 32'he) begin errors++; $display("FAIL eret_code got %h exp e", excepttype_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (new_pc_o !== 32'h0000_2000) begin errors++; $display("FAIL eret_new_pc got %h exp 2000", new_pc_o); end
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL eret_flush got %0b exp 1", flush_o); end
    step();
    step();
  endtask

  task automatic test_int_masking();
    mem_valid_i = 1'b1; cp0_status_i = 32'h0000_FF03; cp0_cause_i = 32'h0000_0400;
    #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL mask_exl got %h exp 0", excepttype_o); end
    step();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL mask_exl_flush got %0b exp 0", flush_o); end
    cp0_status_i = 32'h0; cp0_ebase_i = 32'h9FC0_1234;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_FF01;
    #1;
    checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL mask_fwd_status got %h exp 1", excepttype_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (new_pc_o !== 32'h9FC0_1180) begin errors++; $display("FAIL mask_vector got %h exp 9fc01180", new_pc_o); end
    step();
    step();
    // cause forwarding must not touch IP[7:2]; only IP[1:0] come from WB
    mem_valid_i = 1'b1; cp0_status_i = 32'h0000_0401;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0400;
    #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL mask_cause_hi got %h exp 0", excepttype_o); end
    wb_cp0_data_i = 32'h0000_0100; cp0_status_i = 32'h0000_0101;
    #1;
    checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL mask_cause_sw got %h exp 1", excepttype_o); end
    clear_inputs();
    mem_valid_i = 1'b0; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
    #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL mask_no_valid got %h exp 0", excepttype_o); end
    step();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL mask_no_valid_flush got %0b exp 0", flush_o); end
    clear_inputs();
  endtask

  task automatic test_int_over_eret();
    mem_valid_i = 1'b1; exc_eret_i = 1'b1; cp0_epc_i = 32'h0000_3000;
    cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400; cp0_ebase_i = 32'h8000_0000;
    #1;
    checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL int_eret_code got %h exp 1", excepttype_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (new_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL int_eret_pc got %h exp 80000180", new_pc_o); end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1; cp0_ebase_i = 32'h8000_0000;
    step();
    exc_syscall_i = 1'b0; exc_break_i = 1'b1;
    cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
    #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL b2b_lock1 got %h exp 0", excepttype_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %0b exp 1", busy_o); end
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0;
    step();
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL b2b_lock2 got %h exp 0", excepttype_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy2 got %0b exp 1", busy_o); end
    step();
    checks++; if (excepttype_o !== 32'hf) begin errors++; $display("FAIL b2b_break got %h exp f", excepttype_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b exp 0", busy_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL b2b_flush got %0b exp 1", flush_o); end
    step();
    step();
  endtask

  task automatic test_reset_mid_flush();
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1; cp0_ebase_i = 32'h8000_0000;
    step();
    clear_inputs();
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rmf_pre got %0b exp 1", flush_o); end
    rst = 1'b0;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rmf_flush got %0b exp 0", flush_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmf_busy got %0b exp 0", busy_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL rmf_new_pc got %h exp 0", new_pc_o); end
    step();
    #2 rst = 1'b1;
    step();
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1; mem_in_delayslot_i = 1'b1;
    mem_inst_addr_i = 32'h0040_0010; cp0_ebase_i = 32'hA000_0000;
    #1;
    checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL rmf_code got %h exp 8", excepttype_o); end
    checks++; if (is_in_delayslot_o !== 1'b1) begin errors++; $display("FAIL rmf_ds got %0b exp 1", is_in_delayslot_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rmf_flush_after got %0b exp 1", flush_o); end
    checks++; if (new_pc_o !== 32'hA000_0180) begin errors++; $display("FAIL rmf_pc_after got %h exp a0000180", new_pc_o); end
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_syscall();
    test_priority();
    test_eret_forward();
    test_int_masking();
    test_int_over_eret();
    test_back_to_back();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_except_ctrl.md
Name: cp0_except_ctrl

Overview:
- Exception/interrupt scheduler for the CP0 register block.
- Samples exception flags of the instruction in the MEM stage and arbitrates them against pending interrupts by fixed priority.
- Drives the CP0 excepttype/EPC-source inputs, then sequences the pipeline flush and redirect PC.
- Sits between the MEM stage, the CP0 registers and the ctrl/PC unit; holds further acceptance while a flush is in progress.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o is held after an accepted event (1..15).
- EXC_OFFSET, 32'h00000180, offset added to EBase for the general exception vector.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction.
- mem_inst_addr_i  in  32  PC of the MEM-stage instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- exc_adel_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_ov_i, exc_trap_i, exc_eret_i  in  1 each  exception flags from the MEM stage.
- cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i  in  32 each  current CP0 register values.
- wb_cp0_we_i  in  1  in-flight mtc0 in WB.
- wb_cp0_waddr_i  in  5  its target register (12 status, 13 cause, 14 epc).
- wb_cp0_data_i  in  32  its write data.
- excepttype_o  out  32  encoded event to CP0.
- current_inst_addr_o  out  32  PC to CP0.
- is_in_delayslot_o  out  1  delay-slot flag to CP0.
- flush_o  out  1  pipeline flush.
- new_pc_o  out  32  redirect target, valid while flush_o=1.
- busy_o  out  1  controller in FLUSH state.

Behaviour:
- Reset (rst=0, async): state=IDLE, flush_o=0, new_pc_o=0, busy_o=0, flush counter=0. All combinational outputs read 0 during reset.
- Forwarding: effective status/cause/epc = wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i matches; otherwise the cp0_*_i value. Cause forwarding replaces only bits 9:8, 22 and 23; bits 15:10 always come from cp0_cause_i.
- Interrupt pending = status[0]=1 AND status[1]=0 AND (cause[15:8] & status[15:8]) != 0.
- Events are considered only in IDLE with mem_valid_i=1. Priority, first match wins; code in brackets:
  1. interrupt [32'h1]
  2. adel [32'h10]
  3. ri [32'ha]
  4. syscall [32'h8]
  5. break [32'hf]
  6. ov [32'hc]
  7. trap [32'hd]
  8. eret [32'he]
  9. none [0]
- excepttype_o is combinational and 0 outside IDLE. current_inst_addr_o = mem_inst_addr_i and is_in_delayslot_o = mem_in_delayslot_i, passed through combinationally.
- Accept = excepttype_o != 0 in IDLE. On the accept clock edge:
  - state goes to FLUSH, counter=FLUSH_CYCLES-1.
  - new_pc_o is registered: eret → effective EPC; otherwise → {cp0_ebase_i[31:12],12'h000} + EXC_OFFSET (32-bit wrap).
  - flush_o and busy_o go to 1 the cycle after accept, i.e. one-cycle latency.
- FLUSH: flush_o=1, busy_o=1, new_pc_o held; the counter decrements each cycle. When the counter is 0, the next edge returns to IDLE, with flush_o and busy_o =0 in that cycle. flush_o is high for exactly FLUSH_CYCLES cycles.
- Events arriving during FLUSH are ignored: no excepttype, no state change, even if flags or interrupts persist.
- An interrupt pending on the same cycle as an eret takes the interrupt, and the eret is discarded.
- Reset asserted mid-FLUSH: immediate return to IDLE with all registered outputs 0.
- mem_valid_i=0: no accept, even if an interrupt is pending.

Test Plan:
- Syscall: IDLE, mem_valid_i=1, exc_syscall_i=1, addr 0xBFC00100, ebase 0x80000000 → excepttype_o=0x8 same cycle. Next cycle flush_o=1 and new_pc_o=0x80000180, held 2 cycles, then flush_o=0.
- Priority: ri+ov+eret together → excepttype_o=0xa. Status=0x0000FF01 with cause[10]=1 and syscall set → 0x1.
- ERET with forwarding: cp0_epc_i=0x1000, wb_cp0_we_i=1, waddr=14, data=0x2000, exc_eret_i=1 → excepttype_o=0xe, new_pc_o=0x2000.
- Interrupt masking:
  - status EXL=1 with pending IP → no accept.
  - wb mtc0 to status writing 0x0000FF01 while cp0_status_i=0 → interrupt accepted (0x1).
- Busy lockout: syscall accepted; exc_break_i=1 during both FLUSH cycles → excepttype_o=0, busy_o=1. The break is accepted (0xf) on the first IDLE cycle.
- Reset: rst=0 asserted during FLUSH → flush_o, busy_o, new_pc_o =0 immediately. After release, accept works normally; the delay-slot flag is passed through as is_in_delayslot_o=1.
